// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, IR, BYPASS, BSR sequencing and TDO mux.
// TDO/TDO_EN, ir_q, bs_en, updatedr and the clockdr enable update on the TCK falling edge.
module jtag_tap_ctrl #(
  parameter int unsigned         IR_WIDTH  = 4,
  parameter logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(0),
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] OP_INTEST = IR_WIDTH'(2),
  parameter logic [IR_WIDTH-1:0] OP_BYPASS = '1
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                TDO_BSR,
  output logic                TDO,
  output logic                TDO_EN,
  output logic                clockdr,
  output logic                updatedr,
  output logic                shiftdr,
  output logic                bs_en,
  output logic [IR_WIDTH-1:0] ir_q,
  output logic [3:0]          tap_state
);

  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PAU_DR = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PAU_IR = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_e;

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] ir_d;
  logic                bypass_q, bypass_d;
  logic                bsr_sel;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                clk_en_q, clk_en_d;
  logic                upd_q, upd_d;
  logic                bs_en_q, bs_en_d;

  assign bsr_sel = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE) || (ir_q == OP_INTEST);

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state_q <= TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = TMS ? TLR    : RTI;
      RTI:    state_d = TMS ? SEL_DR : RTI;
      SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
      PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
      EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_d = TMS ? SEL_DR : RTI;
      SEL_IR: state_d = TMS ? TLR    : CAP_IR;
      CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
      PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
      EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_d = TMS ? SEL_DR : RTI;
    endcase
  end

  // Rising-edge shift paths: IR capture/shift and the 1-bit BYPASS register.
  always_comb begin
    ir_sr_d  = ir_sr_q;
    bypass_d = bypass_q;
    case (state_q)
      CAP_IR:  ir_sr_d  = IR_WIDTH'(1);
      SH_IR:   ir_sr_d  = {TDI, ir_sr_q[IR_WIDTH-1:1]};
      CAP_DR:  bypass_d = 1'b0;
      SH_DR:   bypass_d = TDI;
      default: ;
    endcase
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_sr_q  <= '0;
      bypass_q <= 1'b0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      bypass_q <= bypass_d;
    end
  end

  // Falling-edge side: everything here changes while TCK is low, so clockdr cannot glitch.
  always_comb begin
    ir_d = ir_q;
    if (state_q == TLR) begin
      ir_d = OP_BYPASS;
    end else if (state_q == UPD_IR) begin
      ir_d = ir_sr_q;
    end
    bs_en_d  = (ir_d == OP_EXTEST) || (ir_d == OP_INTEST);
    clk_en_d = bsr_sel && ((state_q == CAP_DR) || (state_q == SH_DR));
    upd_d    = bsr_sel && (state_q == UPD_DR);
    tdo_en_d = (state_q == SH_IR) || (state_q == SH_DR);
    tdo_d    = 1'b0;
    if (state_q == SH_IR) begin
      tdo_d = ir_sr_q[0];
    end else if (state_q == SH_DR) begin
      tdo_d = bsr_sel ? TDO_BSR : bypass_q;
    end
  end

  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_q     <= OP_BYPASS;
      bs_en_q  <= 1'b0;
      clk_en_q <= 1'b0;
      upd_q    <= 1'b0;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      bs_en_q  <= bs_en_d;
      clk_en_q <= clk_en_d;
      upd_q    <= upd_d;
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tap_state = state_q;
  assign shiftdr   = (state_q == SH_DR) && bsr_sel;
  assign clockdr   = TCK & clk_en_q;
  assign updatedr  = upd_q;
  assign bs_en     = bs_en_q;
  assign TDO       = tdo_q;
  assign TDO_EN    = tdo_en_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Bench for jtag_tap_ctrl: directed scans against a 72-cell BSR model, then random TMS/TDI/TRST
// checked every half cycle against a behavioural TAP model.
module tb_jtag_tap_ctrl;
  localparam int W  = 4;
  localparam int NB = 72;
  // next-state tables, nibble i = successor of state i
  localparam logic [63:0] NXT0 = 64'hCACC_BABA_62CE_3232;
  localparam logic [63:0] NXT1 = 64'hF977_89DD_417F_0155;

  logic TCK = 1'b0, TRST = 1'b0, TMS = 1'b1, TDI = 1'b0;
  logic TDO_BSR, TDO, TDO_EN, clockdr, updatedr, shiftdr, bs_en;
  logic [W-1:0] ir_q;
  logic [3:0]   tap_state;

  jtag_tap_ctrl #(.IR_WIDTH(W)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO_BSR(TDO_BSR),
    .TDO(TDO), .TDO_EN(TDO_EN), .clockdr(clockdr), .updatedr(updatedr),
    .shiftdr(shiftdr), .bs_en(bs_en), .ir_q(ir_q), .tap_state(tap_state)
  );

  always #5 TCK = ~TCK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 72-cell boundary-scan register driven by the DUT's clockdr/shiftdr
  logic [NB-1:0] bsr = '0;
  logic [NB-1:0] pins = '0;
  logic          sh_lat = 1'b0;
  always @(negedge TCK) sh_lat = shiftdr;
  always @(posedge clockdr) begin
    if (sh_lat) bsr = {TDI, bsr[NB-1:1]};
    else        bsr = pins;
  end
  assign TDO_BSR = bsr[0];

  int act_rises  = 0;
  int upd_pulses = 0;
  always @(posedge clockdr)  act_rises++;
  always @(posedge updatedr) upd_pulses++;

  // behavioural model
  logic [63:0]  n0 = NXT0;
  logic [63:0]  n1 = NXT1;
  logic [3:0]   m_state;
  logic [W-1:0] m_irsr, m_ir;
  logic         m_byp, m_tdo, m_tdoen, m_en, m_upd, m_bsen;
  int           exp_rises = 0;

  function automatic bit sel_f(input logic [W-1:0] ir);
    return (ir == 0) || (ir == 1) || (ir == 2);
  endfunction

  task automatic m_reset();
    m_state = 4'hF; m_irsr = '0; m_ir = '1; m_byp = 1'b0;
    m_tdo = 1'b0; m_tdoen = 1'b0; m_en = 1'b0; m_upd = 1'b0; m_bsen = 1'b0;
  endtask

  always @(posedge TRST) m_reset();

  always @(posedge TCK) begin
    if (TRST) m_reset();
    else begin
      if ((m_state == 4'h6 || m_state == 4'h2) && sel_f(m_ir)) exp_rises++;
      if (m_state == 4'hE)      m_irsr = W'(1);
      else if (m_state == 4'hA) m_irsr = {TDI, m_irsr[W-1:1]};
      if (m_state == 4'h6)      m_byp = 1'b0;
      else if (m_state == 4'h2) m_byp = TDI;
      m_state = TMS ? n1[m_state*4 +: 4] : n0[m_state*4 +: 4];
    end
  end

  always @(negedge TCK) begin
    if (TRST) m_reset();
    else begin
      m_tdoen = (m_state == 4'hA) || (m_state == 4'h2);
      if (m_state == 4'hA)      m_tdo = m_irsr[0];
      else if (m_state == 4'h2) m_tdo = sel_f(m_ir) ? TDO_BSR : m_byp;
      else                      m_tdo = 1'b0;
      m_upd = (m_state == 4'h5) && sel_f(m_ir);
      m_en  = ((m_state == 4'h6) || (m_state == 4'h2)) && sel_f(m_ir);
      if (m_state == 4'hF)      m_ir = '1;
      else if (m_state == 4'hD) m_ir = m_irsr;
      m_bsen = (m_ir == 0) || (m_ir == 2);
    end
  end

  bit run = 1'b0;
  always @(TCK) begin
    #2;
    if (run) begin
      check("tap_state", tap_state, m_state);
      check("ir_q", ir_q, m_ir);
      check("TDO", TDO, m_tdo);
      check("TDO_EN", TDO_EN, m_tdoen);
      check("shiftdr", shiftdr, (m_state == 4'h2) && sel_f(m_ir));
      check("updatedr", updatedr, m_upd);
      check("bs_en", bs_en, m_bsen);
      check("clockdr", clockdr, TCK & m_en);
    end
  end

  task automatic tick(input bit tms, input bit tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #3;
  endtask

  logic cap_shiftdr, sh_shiftdr;
  int   cap_rises, pause_rises;

  // From RTI: scan n bits through IR or DR (optional pause after bit pause_at), back to RTI.
  task automatic scan(input bit is_ir, input logic [127:0] din, input int n,
                      input int pause_at, output logic [127:0] dout);
    int r;
    dout = '0;
    tick(1'b1, 1'b0);
    if (is_ir) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    cap_shiftdr = shiftdr;
    r = act_rises;
    tick(1'b0, 1'b0);
    cap_rises  = act_rises - r;
    sh_shiftdr = shiftdr;
    pause_rises = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge TCK);
      #2;
      dout[i] = TDO;
      tick((i == n - 1) || (i == pause_at), din[i]);
      if (i == pause_at && i != n - 1) begin
        r = act_rises;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        pause_rises = act_rises - r;
      end
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    logic [127:0] din, dout;
    logic [95:0]  rnd;
    int r0, u0;
    rnd  = {$urandom, $urandom, $urandom};
    pins = rnd[NB-1:0];
    #1 TRST = 1'b1;
    run = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("rst_state", tap_state, 4'hF);
    check("rst_ir", ir_q, 4'hF);
    check("rst_bs_en", bs_en, 1'b0);
    check("rst_clockdr", clockdr, 1'b0);
    TRST = 1'b0;

    tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    check("reach_shdr", tap_state, 4'h2);
    repeat (5) tick(1'b1, 1'b0);
    check("tms5_tlr", tap_state, 4'hF);
    tick(1'b0, 1'b0);

    scan(1'b1, 128'h0, 4, -1, dout);
    check("extest_capture_tdo", dout[3:0], 4'b0001);
    check("extest_ir", ir_q, 4'h0);
    check("extest_bs_en", bs_en, 1'b1);

    scan(1'b1, 128'h1, 4, -1, dout);
    check("sample_ir", ir_q, 4'h1);
    check("sample_bs_en", bs_en, 1'b0);
    r0 = act_rises; u0 = upd_pulses;
    rnd = {$urandom, $urandom, $urandom};
    din = {32'h0, rnd};
    scan(1'b0, din, NB, 30, dout);
    check("cap_one_rise", cap_rises, 1);
    check("cap_shiftdr", cap_shiftdr, 1'b0);
    check("sh_shiftdr", sh_shiftdr, 1'b1);
    check("pause_no_rise", pause_rises, 0);
    check("sample_rises", act_rises - r0, NB + 1);
    check("sample_tdo_stream", dout[NB-1:0], pins);
    check("sample_bsr_loaded", bsr, din[NB-1:0]);
    check("sample_upd_pulse", upd_pulses - u0, 1);
    check("sample_bs_en_after", bs_en, 1'b0);

    scan(1'b1, 128'hF, 4, -1, dout);
    check("bypass_ir", ir_q, 4'hF);
    r0 = act_rises; u0 = upd_pulses;
    scan(1'b0, 128'hA5, 9, 3, dout);
    check("bypass_tdo", dout[8:0], 9'h14A);
    check("bypass_no_clockdr", act_rises - r0, 0);
    check("bypass_no_updatedr", upd_pulses - u0, 0);

    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    check("midshift_tdo_en", TDO_EN, 1'b1);
    TRST = 1'b1;
    #1;
    check("trst_state", tap_state, 4'hF);
    check("trst_tdo", TDO, 1'b0);
    check("trst_tdo_en", TDO_EN, 1'b0);
    check("trst_ir_kept", ir_q, 4'hF);
    tick(1'b1, 1'b0);
    TRST = 1'b0;

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        rnd  = {$urandom, $urandom, $urandom};
        pins = rnd[NB-1:0];
      end
      if ($urandom_range(0, 299) == 0) begin
        TRST = 1'b1;
        tick(1'b1, 1'b0);
        TRST = 1'b0;
      end else begin
        tick($urandom_range(0, 99) < 35, 1'($urandom));
      end
    end
    check("total_clockdr_rises", act_rises, exp_rises);

    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
